uart_job_loader: RTL and testbench

Frame parser and job scheduler between the UART receiver and the hashing core. It consumes the receiver's byte strobe and byte output, and assembles framed commands into a staged block header. It hands complete, checksum-verified jobs to the miner through a valid/ready handshake and signals aborts. It also reports framing, checksum, timeout and overrun errors.

---
 rtl/uart_job_loader.sv | 213 +++++++++++++++++++++
 tb/tb_uart_job_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_job_loader.sv
// uart_job_loader: frame parser and job scheduler between the UART receiver
// and the hashing core. It turns receiver bytes into checksum-verified block
// headers and hands them to the miner through a valid/ready handshake.
// Frames: A5 01 <HEADER_BYTES payload> CHK (job) and A5 02 CHK (abort).
// CHK is the XOR of the command byte and all payload bytes.
// Optional feature: define JOB_LOADER_STATS_EN to add the o_Frame_Count and
// o_Err_Count saturating statistics counters.
module uart_job_loader #(
    parameter int          HEADER_BYTES = 76,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 100000
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Rx_DV,
    input  logic [7:0]                i_Rx_Byte,
    output logic [8*HEADER_BYTES-1:0] o_Job_Data,
    output logic                      o_Job_Valid,
    input  logic                      i_Job_Ready,
    output logic                      o_Abort,
    output logic                      o_Busy,
    output logic                      o_Err_Frame,
    output logic                      o_Err_Checksum,
    output logic                      o_Err_Timeout,
    output logic                      o_Err_Overrun
`ifdef JOB_LOADER_STATS_EN
    ,
    output logic [15:0]               o_Frame_Count,
    output logic [15:0]               o_Err_Count
`endif
);

    localparam int IDX_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0] CMD_JOB   = 8'h01;
    localparam logic [7:0] CMD_ABORT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                xor_q, xor_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      is_job_q, is_job_d;
    logic [CNT_W-1:0]          to_cnt_q;
    logic [8*HEADER_BYTES-1:0] staging_q;
    logic                      rx_dv_prev_q;

    logic rx_strobe;
    logic timeout_hit;
    logic stage_wr;
    logic load_job;
    logic abort_cmd;
    logic err_frame;
    logic err_chk;
    logic err_to;
    logic overrun_evt;

    // One strobe per byte: rising edge of DV. The history register resets
    // high so a DV already asserted at reset release is not taken as a byte.
    assign rx_strobe   = i_Rx_DV && !rx_dv_prev_q;
    assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
    assign overrun_evt = load_job && o_Job_Valid && !i_Job_Ready;
    assign o_Busy      = (state_q != ST_IDLE);

    // Registered copy of DV for strobe detection.
    always_ff @(posedge i_Clock) begin
        // NOTE: clocked state is always assigned with <= so every register
        // samples pre-edge values; blocking = here would create ordering races.
        if (i_Reset) rx_dv_prev_q <= 1'b1;
        else         rx_dv_prev_q <= i_Rx_DV;
    end

    // Parser state register with its running checksum, index and frame kind.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            xor_q    <= 8'h00;
            idx_q    <= '0;
            is_job_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            xor_q    <= xor_d;
            idx_q    <= idx_d;
            is_job_q <= is_job_d;
        end
    end

    // Next-state decode: one byte per strobe, timeout only when no byte arrives.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        xor_d     = xor_q;
        idx_d     = idx_q;
        is_job_d  = is_job_q;
        stage_wr  = 1'b0;
        load_job  = 1'b0;
        abort_cmd = 1'b0;
        err_frame = 1'b0;
        err_chk   = 1'b0;
        err_to    = 1'b0;

        if (rx_strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (i_Rx_Byte == CMD_JOB) begin
                        xor_d    = CMD_JOB;
                        idx_d    = '0;
                        is_job_d = 1'b1;
                        state_d  = ST_PAYLOAD;
                    end else if (i_Rx_Byte == CMD_ABORT) begin
                        xor_d    = CMD_ABORT;
                        is_job_d = 1'b0;
                        state_d  = ST_CHECK;
                    end else begin
                        err_frame = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    // A sync byte is ordinary data inside the payload.
                    stage_wr = 1'b1;
                    xor_d    = xor_q ^ i_Rx_Byte;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == IDX_W'(HEADER_BYTES - 1)) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (i_Rx_Byte != xor_q) err_chk   = 1'b1;
                    else if (is_job_q)      load_job  = 1'b1;
                    else                    abort_cmd = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            err_to  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Inter-byte timeout counter: idle and every strobe restart it.
    always_ff @(posedge i_Clock) begin
        if (i_Reset || rx_strobe || state_q == ST_IDLE || err_to) to_cnt_q <= '0;
        else                                                     to_cnt_q <= to_cnt_q + 1'b1;
    end

    // Staging register: payload byte 0 lands in the most significant byte.
    always_ff @(posedge i_Clock) begin
        // NOTE: this wide register is cleared on reset because the reset state
        // of o_Job_Data is defined and a stale header must never leak out.
        if (i_Reset)       staging_q <= '0;
        else if (stage_wr) staging_q[(HEADER_BYTES - 1 - int'(idx_q)) * 8 +: 8] <= i_Rx_Byte;
    end

    // Output side: job hand-off, abort and one-cycle status pulses.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Job_Data     <= '0;
            o_Job_Valid    <= 1'b0;
            o_Abort        <= 1'b0;
            o_Err_Frame    <= 1'b0;
            o_Err_Checksum <= 1'b0;
            o_Err_Timeout  <= 1'b0;
            o_Err_Overrun  <= 1'b0;
        end else begin
            o_Abort        <= abort_cmd;
            o_Err_Frame    <= err_frame;
            o_Err_Checksum <= err_chk;
            o_Err_Timeout  <= err_to;
            o_Err_Overrun  <= overrun_evt;
            if (load_job) begin
                // Latest job wins; a same-edge transfer hands off the old one.
                o_Job_Data  <= staging_q;
                o_Job_Valid <= 1'b1;
            end else if (abort_cmd) begin
                o_Job_Valid <= 1'b0;
            end else if (o_Job_Valid && i_Job_Ready) begin
                o_Job_Valid <= 1'b0;
            end
        end
    end

`ifdef JOB_LOADER_STATS_EN
    logic [2:0]  err_events;
    logic [16:0] err_sum;

    assign err_events = 3'(err_frame) + 3'(err_chk) + 3'(err_to) + 3'(overrun_evt);
    assign err_sum    = {1'b0, o_Err_Count} + 17'(err_events);

    // Saturating counters of accepted frames and of error pulses.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Frame_Count <= 16'h0000;
            o_Err_Count   <= 16'h0000;
        end else begin
            if ((load_job || abort_cmd) && o_Frame_Count != 16'hFFFF)
                o_Frame_Count <= o_Frame_Count + 16'h0001;
            o_Err_Count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_uart_job_loader.sv
// Directed bench for uart_job_loader with a short timeout; expected headers are
// queued when a frame is sent and compared when the job appears.
module tb_uart_job_loader;

    localparam int HB = 76;
    localparam int TO = 64;
    localparam int W  = 8 * HB;

    logic         i_Clock = 1'b0;
    logic         i_Reset;
    logic         i_Rx_DV;
    logic [7:0]   i_Rx_Byte;
    logic [W-1:0] o_Job_Data;
    logic         o_Job_Valid;
    logic         i_Job_Ready;
    logic         o_Abort;
    logic         o_Busy;
    logic         o_Err_Frame;
    logic         o_Err_Checksum;
    logic         o_Err_Timeout;
    logic         o_Err_Overrun;
`ifdef JOB_LOADER_STATS_EN
    logic [15:0]  o_Frame_Count;
    logic [15:0]  o_Err_Count;
`endif

    uart_job_loader #(.HEADER_BYTES(HB), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Rx_DV        (i_Rx_DV),
        .i_Rx_Byte      (i_Rx_Byte),
        .o_Job_Data     (o_Job_Data),
        .o_Job_Valid    (o_Job_Valid),
        .i_Job_Ready    (i_Job_Ready),
        .o_Abort        (o_Abort),
        .o_Busy         (o_Busy),
        .o_Err_Frame    (o_Err_Frame),
        .o_Err_Checksum (o_Err_Checksum),
        .o_Err_Timeout  (o_Err_Timeout),
        .o_Err_Overrun  (o_Err_Overrun)
`ifdef JOB_LOADER_STATS_EN
        ,
        .o_Frame_Count  (o_Frame_Count),
        .o_Err_Count    (o_Err_Count)
`endif
    );

    always #5 i_Clock = ~i_Clock;

    int total = 0;
    int bad   = 0;
    int n_abort = 0, n_frame = 0, n_chk = 0, n_to = 0, n_ovr = 0;
    logic [W-1:0] exp_q[$];

    // Count pulse cycles away from the active edge.
    always @(negedge i_Clock) begin
        if (o_Abort)        n_abort++;
        if (o_Err_Frame)    n_frame++;
        if (o_Err_Checksum) n_chk++;
        if (o_Err_Timeout)  n_to++;
        if (o_Err_Overrun)  n_ovr++;
    end

    // Run-time bound: the directed sequence needs only a few thousand cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ramp(input logic [7:0] start);
        logic [W-1:0] p;
        for (int i = 0; i < HB; i++) p[W-1-8*i -: 8] = start + 8'(i);
        return p;
    endfunction

    function automatic logic [W-1:0] rand_payload();
        logic [W-1:0] p;
        for (int i = 0; i < HB; i++) p[W-1-8*i -: 8] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    function automatic logic [7:0] job_chk(input logic [W-1:0] p);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 0; i < HB; i++) c = c ^ p[W-1-8*i -: 8];
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    // One byte: DV high for 'hold' cycles then low for one; ready optionally
    // asserted over exactly the edge that samples this byte's strobe.
    task automatic send_byte(input logic [7:0] b, input int hold, input logic rdy);
        @(negedge i_Clock);
        i_Rx_Byte   = b;
        i_Rx_DV     = 1'b1;
        i_Job_Ready = rdy;
        @(negedge i_Clock);
        i_Job_Ready = 1'b0;
        repeat (hold - 1) @(negedge i_Clock);
        i_Rx_DV = 1'b0;
    endtask

    task automatic send_job(input logic [W-1:0] p, input bit corrupt, input int hold, input logic rdy_on_chk);
        logic [7:0] c;
        c = job_chk(p);
        if (corrupt) c = ~c;
        send_byte(8'hA5, hold, 1'b0);
        send_byte(8'h01, hold, 1'b0);
        for (int i = 0; i < HB; i++) send_byte(p[W-1-8*i -: 8], hold, 1'b0);
        send_byte(c, hold, rdy_on_chk);
    endtask

    task automatic expect_job(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_bit({tag, "_valid"}, o_Job_Valid, 1'b1);
        check_vec({tag, "_data"}, o_Job_Data, e);
    endtask

    task automatic pulse_ready();
        @(negedge i_Clock);
        i_Job_Ready = 1'b1;
        @(negedge i_Clock);
        i_Job_Ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] p0, p1, p2, pa, pb, pc, pd, pe, pf;
        int c0, w, e0;

        i_Reset     = 1'b1;
        i_Rx_DV     = 1'b0;
        i_Rx_Byte   = 8'h00;
        i_Job_Ready = 1'b0;
        tick(3);
        check_bit("rst_valid", o_Job_Valid, 1'b0);
        check_vec("rst_data", o_Job_Data, '0);
        check_bit("rst_busy", o_Busy, 1'b0);
        check_int("rst_pulses", int'({o_Abort, o_Err_Frame, o_Err_Checksum, o_Err_Timeout, o_Err_Overrun}), 0);

        // DV high with a sync byte across reset release: no strobe.
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = 8'hA5;
        tick(1);
        i_Reset = 1'b0;
        tick(3);
        check_bit("dv_at_release_busy", o_Busy, 1'b0);
        i_Rx_DV = 1'b0;

        // Idle noise, including a command byte, is silently ignored.
        send_byte(8'h33, 1, 1'b0);
        send_byte(8'h02, 1, 1'b0);
        tick(2);
        check_bit("idle_noise_busy", o_Busy, 1'b0);
        check_int("idle_noise_err", n_frame + n_chk + n_abort, 0);

        // Valid job 00..4B, miner not ready.
        p0 = ramp(8'h00);
        exp_q.push_back(p0);
        send_job(p0, 0, 1, 1'b0);
        tick(2);
        expect_job("job0");
        check_int("job0_first_byte", int'(o_Job_Data[607:600]), 'h00);
        check_int("job0_last_byte", int'(o_Job_Data[7:0]), 'h4B);
        check_bit("job0_busy", o_Busy, 1'b0);
        check_int("job0_no_overrun", n_ovr, 0);
        pulse_ready();
        check_bit("job0_taken", o_Job_Valid, 1'b0);

        // Same frame, inverted checksum.
        c0 = n_chk;
        send_job(p0, 1, 1, 1'b0);
        tick(2);
        check_int("badchk_pulse", n_chk, c0 + 1);
        check_bit("badchk_valid", o_Job_Valid, 1'b0);
        check_vec("badchk_data", o_Job_Data, p0);

        // Abort while a job is pending, then an unknown command.
        p1 = ramp(8'h80);
        exp_q.push_back(p1);
        send_job(p1, 0, 1, 1'b0);
        tick(2);
        expect_job("job1");
        c0 = n_abort;
        send_byte(8'hA5, 1, 1'b0);
        send_byte(8'h02, 1, 1'b0);
        send_byte(8'h02, 1, 1'b0);
        tick(2);
        check_int("abort_pulse", n_abort, c0 + 1);
        check_bit("abort_valid", o_Job_Valid, 1'b0);
        check_vec("abort_data_kept", o_Job_Data, p1);
        c0 = n_frame;
        send_byte(8'hA5, 1, 1'b0);
        send_byte(8'h07, 1, 1'b0);
        tick(2);
        check_int("badcmd_pulse", n_frame, c0 + 1);
        check_bit("badcmd_busy", o_Busy, 1'b0);

        // Timeout after 40 payload bytes.
        c0 = n_to;
        send_byte(8'hA5, 1, 1'b0);
        check_bit("sync_busy", o_Busy, 1'b1);
        send_byte(8'h01, 1, 1'b0);
        for (int i = 0; i < 40; i++) send_byte(8'(i + 3), 1, 1'b0);
        w = 0;
        while (!o_Err_Timeout && w < 200) begin
            @(negedge i_Clock);
            w++;
        end
        check_int("timeout_delay", w, TO);
        check_bit("timeout_busy", o_Busy, 1'b0);
        tick(2);
        check_int("timeout_pulse", n_to, c0 + 1);
        p2 = rand_payload();
        exp_q.push_back(p2);
        send_job(p2, 0, 1, 1'b0);
        tick(2);
        expect_job("after_timeout");
        pulse_ready();

        // Back-to-back jobs without ready: overrun, latest wins.
        c0 = n_ovr;
        pa = rand_payload();
        pb = rand_payload();
        exp_q.push_back(pa);
        send_job(pa, 0, 1, 1'b0);
        tick(2);
        expect_job("ovr_first");
        exp_q.push_back(pb);
        send_job(pb, 0, 1, 1'b0);
        tick(2);
        expect_job("ovr_second");
        check_int("ovr_pulse", n_ovr, c0 + 1);

        // Ready on the exact load edge: transfer plus load, no overrun.
        pc = rand_payload();
        exp_q.push_back(pc);
        send_job(pc, 0, 1, 1'b1);
        tick(2);
        check_int("sameedge_no_ovr", n_ovr, c0 + 1);
        expect_job("sameedge");
        pulse_ready();
        check_bit("sameedge_taken", o_Job_Valid, 1'b0);

        // DV held three cycles per byte.
        e0 = n_frame + n_chk + n_to;
        pd = rand_payload();
        exp_q.push_back(pd);
        send_job(pd, 0, 3, 1'b0);
        tick(2);
        expect_job("slow_dv");
        c0 = n_abort;
        send_byte(8'hA5, 3, 1'b0);
        send_byte(8'h02, 3, 1'b0);
        send_byte(8'h02, 3, 1'b0);
        tick(2);
        check_int("slow_abort", n_abort, c0 + 1);
        check_bit("slow_abort_valid", o_Job_Valid, 1'b0);
        check_int("slow_no_err", n_frame + n_chk + n_to, e0);

        // Reset mid-frame with a job pending and DV high across release.
        pe = rand_payload();
        exp_q.push_back(pe);
        send_job(pe, 0, 1, 1'b0);
        tick(2);
        expect_job("pre_reset");
        send_byte(8'hA5, 1, 1'b0);
        send_byte(8'h01, 1, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(i), 1, 1'b0);
        @(negedge i_Clock);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = 8'hA5;
        i_Reset   = 1'b1;
        tick(2);
        i_Reset = 1'b0;
        tick(3);
        check_bit("midreset_valid", o_Job_Valid, 1'b0);
        check_vec("midreset_data", o_Job_Data, '0);
        check_bit("midreset_busy", o_Busy, 1'b0);
        i_Rx_DV = 1'b0;
        e0 = n_frame + n_chk + n_to;
        pf = rand_payload();
        exp_q.push_back(pf);
        send_job(pf, 0, 3, 1'b0);
        tick(2);
        expect_job("post_reset");
        check_int("post_reset_no_err", n_frame + n_chk + n_to, e0);
        check_int("scoreboard_empty", exp_q.size(), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
